// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, execute-stage state encoding, default widths.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package cpu_pkg;

  // Datapath defaults shared with the register file and control unit.
  localparam int CPU_WIDTH  = 32;
  localparam int CPU_ADDR_W = 5;

  // SELECT opcodes.
  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // Execute-stage FSM encoding.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_WB      = 2'd2;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial-product step per clock.
// Latency: WIDTH steps after load; last=1 flags the step that completes the product.
// Backpressure: none; the owner asserts step only while it wants the datapath to advance.
//
// Ports:
//   CLK, RESET          clock, async active-high reset (clears all state)
//   load                capture mcand_in/mplier_in, clear acc and count
//   step                perform one iteration (ignored when load is high)
//   mcand_in, mplier_in operands captured on load
//   acc_next            accumulator value after the current step (the product on the last step)
//   last                current step is iteration WIDTH
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic [WIDTH-1:0] acc_next,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  // Add the shifted multiplicand when the current multiplier bit is set; carry out is dropped.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (count == CW'(WIDTH - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative MUL, registered write-back to the register file.
// Latency: non-MUL enters WB on the accepting edge; MUL enters WB WIDTH edges after acceptance.
// Backpressure: START is only accepted while BUSY=0; requests during MUL_RUN/WB are dropped, upstream holds.
//
// Ports:
//   CLK, RESET            clock, async active-high reset
//   START                 request strobe, sampled in IDLE only
//   SELECT                opcode (cpu_pkg OP_*)
//   DATA1, DATA2          operands from register file OUT1/OUT2; shift amount is DATA2[4:0]
//   DEST                  destination register address
//   RESULT, WR_ADDR       registered write data/address for register file IN/INADDRESS
//   WRITE_EN              one-cycle write strobe (WB state), drives WRITE
//   ZERO                  RESULT==0, meaningful while WRITE_EN=1
//   BUSY                  high whenever not IDLE
module exec_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH  = CPU_WIDTH,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [2:0]        SELECT,
  input  logic [WIDTH-1:0]  DATA1,
  input  logic [WIDTH-1:0]  DATA2,
  input  logic [ADDR_W-1:0] DEST,
  output logic [WIDTH-1:0]  RESULT,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              WRITE_EN,
  output logic              ZERO,
  output logic              BUSY
);

  logic [1:0]       state;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       shamt;
  logic             accept;
  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] mul_acc_next;
  logic             mul_last;

  assign shamt    = DATA2[4:0];
  assign accept   = (state == S_IDLE) && START;
  assign mul_load = accept && (SELECT == OP_MUL);
  assign mul_step = (state == S_MUL_RUN);
  assign BUSY     = (state != S_IDLE);

  // Single-cycle result; the MUL arm is a don't-care because MUL never takes this path.
  always_comb begin
    alu_res = DATA2;
    unique case (SELECT)
      OP_FWD:  alu_res = DATA2;
      OP_ADD:  alu_res = DATA1 + DATA2;
      OP_AND:  alu_res = DATA1 & DATA2;
      OP_OR:   alu_res = DATA1 | DATA2;
      OP_SLL:  alu_res = DATA1 << shamt;
      OP_SRL:  alu_res = DATA1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(DATA1) >>> shamt);
      default: alu_res = DATA2;
    endcase
  end

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (mul_load),
    .step     (mul_step),
    .mcand_in (DATA1),
    .mplier_in(DATA2),
    .acc_next (mul_acc_next),
    .last     (mul_last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      RESULT   <= '0;
      WR_ADDR  <= '0;
      WRITE_EN <= 1'b0;
      ZERO     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            WR_ADDR <= DEST;
            if (SELECT == OP_MUL) begin
              state <= S_MUL_RUN;
            end else begin
              RESULT   <= alu_res;
              ZERO     <= (alu_res == '0);
              WRITE_EN <= 1'b1;
              state    <= S_WB;
            end
          end
        end
        S_MUL_RUN: begin
          // Capture the accumulator as it leaves the final iteration.
          if (mul_last) begin
            RESULT   <= mul_acc_next;
            ZERO     <= (mul_acc_next == '0);
            WRITE_EN <= 1'b1;
            state    <= S_WB;
          end
        end
        S_WB: begin
          WRITE_EN <= 1'b0;
          ZERO     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          WRITE_EN <= 1'b0;
          ZERO     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
